// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state
// encodings and the default operand width.
package serial_adder_ctrl_pkg;

  // Default operand/sum width in bits.
  localparam int DEFAULT_WIDTH = 8;

  // Controller states. Encoding 2'd3 is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/fullAdder.sv
// One-bit full-adder slice built from two half adders; the two partial
// carries can never both be set, so an OR merges them into the carry-out.
module fullAdder (
  input  logic faOp1,
  input  logic faOp2,
  input  logic faCi,
  output logic faRes,
  output logic faCo
);

  logic ha0_res;
  logic ha0_co;
  logic ha1_co;

  // First stage adds the two operand bits.
  halfAdder u_ha0 (
    .haOp1 (faOp1),
    .haOp2 (faOp2),
    .haRes (ha0_res),
    .haCo  (ha0_co)
  );

  // Second stage folds in the carry from the previous bit.
  halfAdder u_ha1 (
    .haOp1 (ha0_res),
    .haOp2 (faCi),
    .haRes (faRes),
    .haCo  (ha1_co)
  );

  assign faCo = ha0_co | ha1_co;

endmodule

// File: rtl/halfAdder.sv
// One-bit half adder: sum is the XOR of the inputs, carry is the AND.
module halfAdder (
  input  logic haOp1,
  input  logic haOp2,
  output logic haRes,
  output logic haCo
);

  assign haRes = haOp1 ^ haOp2;
  assign haCo  = haOp1 & haOp2;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial addition controller. Operands are captured on an accepted
// start, then shifted LSB-first through a single full-adder slice at one
// bit per clock with the carry held in a flip-flop. The sum and final
// carry are registered on the last bit together with a one-cycle done.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carryOut
);

  // Counter only has to reach WIDTH-1; keep at least one bit for WIDTH=2.
  localparam int              CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e             state_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   r_q;
  logic               c_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   sum_q;
  logic               cout_q;
  logic               busy_q;
  logic               done_q;

  logic               slice_s;
  logic               slice_co;
  logic [WIDTH-1:0]   a_d;
  logic [WIDTH-1:0]   b_d;
  logic [WIDTH-1:0]   r_d;

  // The single adder slice always looks at the current LSBs and carry.
  fullAdder u_fa (
    .faOp1 (a_q[0]),
    .faOp2 (b_q[0]),
    .faCi  (c_q),
    .faRes (slice_s),
    .faCo  (slice_co)
  );

  // Next values of the shift registers for one RUN step; the new sum bit
  // enters at the MSB so that after WIDTH steps bit 0 sits at R[0].
  always_comb begin
    a_d = {1'b0, a_q[WIDTH-1:1]};
    b_d = {1'b0, b_q[WIDTH-1:1]};
    r_d = {slice_s, r_q[WIDTH-1:1]};
  end

  // Controller FSM with datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        // IDLE and DONE both accept a new request; DONE also ends the pulse.
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= op1;
            b_q     <= op2;
            r_q     <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end

        // One bit per clock; start is ignored here and not remembered.
        S_RUN: begin
          a_q   <= a_d;
          b_q   <= b_d;
          r_q   <= r_d;
          c_q   <= slice_co;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            sum_q   <= r_d;
            cout_q  <= slice_co;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end

        // Unused encoding: fall back to a quiet IDLE.
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign sum      = sum_q;
  assign carryOut = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl at WIDTH=8 and WIDTH=3.
// Expected {carryOut,sum} values are queued when a start is accepted and
// compared when the matching done pulse appears.
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start8 = 1'b0;
  logic       start3 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic [2:0] a3 = '0;
  logic [2:0] b3 = '0;

  logic       busy8, done8, co8;
  logic [7:0] sum8;
  logic       busy3, done3, co3;
  logic [2:0] sum3;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [8:0] q8[$];
  logic [3:0] q3[$];
  logic [8:0] e8;
  logic [3:0] e3;
  int  dones8 = 0;
  int  dones3 = 0;
  int  last8  = -1;
  int  last3  = -1;
  logic pd8 = 1'b0;
  logic pd3 = 1'b0;

  serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
    .clk      (clk),
    .rst      (rst),
    .start    (start8),
    .op1      (a8),
    .op2      (b8),
    .busy     (busy8),
    .done     (done8),
    .sum      (sum8),
    .carryOut (co8)
  );

  serial_adder_ctrl #(.WIDTH(3)) u_dut3 (
    .clk      (clk),
    .rst      (rst),
    .start    (start3),
    .op1      (a3),
    .op2      (b3),
    .busy     (busy3),
    .done     (done3),
    .sum      (sum3),
    .carryOut (co3)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard for the 8-bit instance.
  always begin
    @(negedge clk);
    if (done8 === 1'b1) begin
      dones8++;
      chk_eq("done8_single_cycle", 32'(pd8), 32'd0);
      if (q8.size() == 0) begin
        chk_eq("done8_unexpected", 32'd1, 32'd0);
      end else begin
        e8 = q8.pop_front();
        chk_eq("result8", 32'({co8, sum8}), 32'(e8));
      end
      if (last8 >= 0) chk_eq("spacing8", 32'((cyc - last8) >= 9), 32'd1);
      last8 = cyc;
    end
    pd8 = done8;
  end

  // Scoreboard for the 3-bit instance.
  always begin
    @(negedge clk);
    if (done3 === 1'b1) begin
      dones3++;
      chk_eq("done3_single_cycle", 32'(pd3), 32'd0);
      if (q3.size() == 0) begin
        chk_eq("done3_unexpected", 32'd1, 32'd0);
      end else begin
        e3 = q3.pop_front();
        chk_eq("result3", 32'({co3, sum3}), 32'(e3));
      end
      if (last3 >= 0) chk_eq("spacing3", 32'((cyc - last3) >= 4), 32'd1);
      last3 = cyc;
    end
    pd3 = done3;
  end

  task automatic go8(input logic [7:0] x, input logic [7:0] y);
    @(negedge clk);
    a8 = x; b8 = y; start8 = 1'b1;
    q8.push_back(9'(x) + 9'(y));
    @(posedge clk); #1;
    start8 = 1'b0;
  endtask

  task automatic go3(input logic [2:0] x, input logic [2:0] y);
    @(negedge clk);
    a3 = x; b3 = y; start3 = 1'b1;
    q3.push_back(4'(x) + 4'(y));
    @(posedge clk); #1;
    start3 = 1'b0;
  endtask

  // Waits for done8; lat counts negedges, bc counts busy cycles seen.
  task automatic wait8(output int lat, output int bc);
    lat = 0; bc = 0;
    while (1'b1) begin
      @(negedge clk);
      lat++;
      if (busy8 === 1'b1) bc++;
      if (done8 === 1'b1) break;
      if (lat >= 40) begin
        chk_eq("timeout8", 32'd1, 32'd0);
        break;
      end
    end
  endtask

  task automatic wait3(output int lat);
    lat = 0;
    while (1'b1) begin
      @(negedge clk);
      lat++;
      if (done3 === 1'b1) break;
      if (lat >= 40) begin
        chk_eq("timeout3", 32'd1, 32'd0);
        break;
      end
    end
  endtask

  task automatic sweep8(input int n);
    int lat, bc;
    logic [7:0] x, y;
    x = 8'($urandom); y = 8'($urandom);
    go8(x, y);
    for (int i = 1; i < n; i++) begin
      wait8(lat, bc);
      x = 8'($urandom); y = 8'($urandom);
      if ($urandom_range(1, 0) == 1) begin
        a8 = x; b8 = y; start8 = 1'b1;
        q8.push_back(9'(x) + 9'(y));
        @(posedge clk); #1;
        start8 = 1'b0;
      end else begin
        go8(x, y);
      end
    end
    wait8(lat, bc);
  endtask

  task automatic sweep3(input int n);
    int lat;
    logic [2:0] x, y;
    x = 3'($urandom); y = 3'($urandom);
    go3(x, y);
    for (int i = 1; i < n; i++) begin
      wait3(lat);
      x = 3'($urandom); y = 3'($urandom);
      if ($urandom_range(1, 0) == 1) begin
        a3 = x; b3 = y; start3 = 1'b1;
        q3.push_back(4'(x) + 4'(y));
        @(posedge clk); #1;
        start3 = 1'b0;
      end else begin
        go3(x, y);
      end
    end
    wait3(lat);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bc, d0, k;

    // Reset state
    repeat (3) @(negedge clk);
    chk_eq("rst_busy8", 32'(busy8), 32'd0);
    chk_eq("rst_done8", 32'(done8), 32'd0);
    chk_eq("rst_sum8",  32'(sum8),  32'd0);
    chk_eq("rst_co8",   32'(co8),   32'd0);
    chk_eq("rst_busy3", 32'(busy3), 32'd0);
    chk_eq("rst_sum3",  32'(sum3),  32'd0);
    rst = 1'b0;

    // 0x0F + 0x01: latency and busy length
    go8(8'h0F, 8'h01);
    wait8(lat, bc);
    chk_eq("lat_0f01", 32'(lat), 32'd9);
    chk_eq("busy_len_0f01", 32'(bc), 32'd8);
    chk_eq("sum_0f01", 32'(sum8), 32'h10);
    chk_eq("co_0f01", 32'(co8), 32'd0);

    // Carry-producing and zero cases
    go8(8'hFF, 8'h01);
    wait8(lat, bc);
    chk_eq("sum_ff01", 32'(sum8), 32'h00);
    chk_eq("co_ff01", 32'(co8), 32'd1);
    go8(8'hFF, 8'hFF);
    wait8(lat, bc);
    chk_eq("sum_ffff", 32'(sum8), 32'hFE);
    chk_eq("co_ffff", 32'(co8), 32'd1);
    go8(8'h00, 8'h00);
    wait8(lat, bc);
    chk_eq("sum_0000", 32'(sum8), 32'h00);
    chk_eq("co_0000", 32'(co8), 32'd0);

    // start during RUN is ignored
    d0 = dones8;
    go8(8'h05, 8'h03);
    repeat (3) @(negedge clk);
    a8 = 8'hAA; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    wait8(lat, bc);
    chk_eq("sum_ignored_start", 32'(sum8), 32'h08);
    repeat (12) @(negedge clk);
    chk_eq("one_done_ignored_start", 32'(dones8 - d0), 32'd1);
    chk_eq("idle_after_ignored", 32'(busy8), 32'd0);

    // Reset in the 4th RUN cycle aborts the run
    go8(8'h7F, 8'h01);
    repeat (4) @(negedge clk);
    chk_eq("busy_before_rst", 32'(busy8), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk_eq("abort_busy", 32'(busy8), 32'd0);
    chk_eq("abort_done", 32'(done8), 32'd0);
    chk_eq("abort_sum",  32'(sum8),  32'd0);
    chk_eq("abort_co",   32'(co8),   32'd0);
    rst = 1'b0;
    q8.delete();
    d0 = dones8;
    repeat (15) @(negedge clk);
    chk_eq("no_done_after_abort", 32'(dones8 - d0), 32'd0);

    // Back-to-back: start held in DONE
    go8(8'h12, 8'h34);
    wait8(lat, bc);
    chk_eq("sum_1234", 32'(sum8), 32'h46);
    a8 = 8'h80; b8 = 8'h80; start8 = 1'b1;
    q8.push_back(9'h100);
    @(posedge clk); #1;
    start8 = 1'b0;
    k = 0;
    while (k < 30) begin
      @(negedge clk);
      k++;
      if (k == 1) chk_eq("b2b_busy_no_idle", 32'(busy8), 32'd1);
      if (done8 === 1'b1) break;
      if (k == 4) begin
        chk_eq("b2b_sum_held", 32'(sum8), 32'h46);
        chk_eq("b2b_co_held", 32'(co8), 32'd0);
      end
    end
    chk_eq("b2b_done_gap", 32'(k), 32'd9);
    chk_eq("b2b_sum", 32'(sum8), 32'h00);
    chk_eq("b2b_co", 32'(co8), 32'd1);

    // Random sweeps
    sweep8(1000);
    sweep3(1000);

    repeat (5) @(negedge clk);
    chk_eq("q8_drained", 32'(q8.size()), 32'd0);
    chk_eq("q3_drained", 32'(q3.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
